// File: rtl/mem_access_unit.sv
// rtl/mem_access_unit.sv - range-checked single-outstanding load/store front end for Memory
module mem_access_unit #(
    parameter int                  ADDR_W        = 16,
    parameter int                  DATA_W        = 32,
    parameter logic [ADDR_W-1:0]   STATIC_BASE   = 16'h0000,
    parameter logic [ADDR_W-1:0]   STATIC_SPACE  = 16'h0FFF,
    parameter logic [ADDR_W-1:0]   DYNAMIC_BASE  = 16'h8000,
    parameter logic [ADDR_W-1:0]   DYNAMIC_SPACE = 16'h0FFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_enable_write,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_out,
    output logic [7:0]        fault_count
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_data_q, resp_data_d;
    logic              resp_fault_q, resp_fault_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_write_data_q, mem_write_data_d;
    logic              write_q, write_d;
    logic [7:0]        fault_count_q, fault_count_d;

    // Offset from each base wraps for addresses below the base, so one
    // unsigned compare covers both inclusive bounds.
    logic [ADDR_W-1:0] static_off;
    logic [ADDR_W-1:0] dynamic_off;
    logic              in_range;

    assign static_off  = req_addr - STATIC_BASE;
    assign dynamic_off = req_addr - DYNAMIC_BASE;
    assign in_range    = (static_off <= STATIC_SPACE) || (dynamic_off <= DYNAMIC_SPACE);

    always_comb begin
        state_d          = state_q;
        req_ready_d      = req_ready_q;
        resp_valid_d     = resp_valid_q;
        resp_data_d      = resp_data_q;
        resp_fault_d     = resp_fault_q;
        mem_addr_d       = mem_addr_q;
        mem_write_data_d = mem_write_data_q;
        write_d          = write_q;
        fault_count_d    = fault_count_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d          = req_write;
                    mem_addr_d       = req_addr;
                    mem_write_data_d = req_wdata;
                    req_ready_d      = 1'b0;
                    if (in_range) begin
                        state_d = ACCESS;
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_fault_d = 1'b1;
                        resp_data_d  = '0;
                        if (fault_count_q != 8'hFF) begin
                            fault_count_d = fault_count_q + 8'd1;
                        end
                    end
                end
            end
            ACCESS: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_fault_d = 1'b0;
                resp_data_d  = write_q ? '0 : mem_read_out;
            end
            RESP: begin
                if (resp_ready) begin
                    state_d      = IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d      = IDLE;
                req_ready_d  = 1'b1;
                resp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            req_ready_q      <= 1'b1;
            resp_valid_q     <= 1'b0;
            resp_data_q      <= '0;
            resp_fault_q     <= 1'b0;
            mem_addr_q       <= '0;
            mem_write_data_q <= '0;
            write_q          <= 1'b0;
            fault_count_q    <= 8'd0;
        end else begin
            state_q          <= state_d;
            req_ready_q      <= req_ready_d;
            resp_valid_q     <= resp_valid_d;
            resp_data_q      <= resp_data_d;
            resp_fault_q     <= resp_fault_d;
            mem_addr_q       <= mem_addr_d;
            mem_write_data_q <= mem_write_data_d;
            write_q          <= write_d;
            fault_count_q    <= fault_count_d;
        end
    end

    // Gated by rst_n so a reset landing in ACCESS cancels the store.
    assign mem_enable_write = (state_q == ACCESS) && write_q && rst_n;

    assign req_ready      = req_ready_q;
    assign resp_valid     = resp_valid_q;
    assign resp_data      = resp_data_q;
    assign resp_fault     = resp_fault_q;
    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_write_data_q;
    assign fault_count    = fault_count_q;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Request-side front end placed directly upstream of the main Memory block.
- Takes one load/store request at a time from the execute stage over a valid/ready handshake.
- Range-checks the address against the static and dynamic memory windows, then drives Memory's address, write-enable and write-data pins.
- Returns the read data, or a fault flag, over a valid/ready response channel; also keeps a saturating fault counter.

Parameters:
ADDR_W, 16, address width (matches addr_t)
DATA_W, 32, data width (matches op_t)
STATIC_BASE, 16'h0000, first valid static address
STATIC_SPACE, 16'h0FFF, static window is STATIC_BASE..STATIC_BASE+STATIC_SPACE inclusive
DYNAMIC_BASE, 16'h8000, first valid dynamic address
DYNAMIC_SPACE, 16'h0FFF, dynamic window is DYNAMIC_BASE..DYNAMIC_BASE+DYNAMIC_SPACE inclusive

Ports:
clk  in  1  clock
rst_n  in  1  synchronous reset, active-low
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_write  in  1  1=store, 0=load
req_addr  in  ADDR_W  request address
req_wdata  in  DATA_W  store data
resp_valid  out  1  response present
resp_ready  in  1  consumer takes response
resp_data  out  DATA_W  load data (0 for stores and faults)
resp_fault  out  1  address outside both windows
mem_addr  out  ADDR_W  to Memory addr
mem_enable_write  out  1  to Memory enable_write
mem_write_data  out  DATA_W  to Memory write_data
mem_read_out  in  DATA_W  from Memory read_out (combinational read)
fault_count  out  8  saturating count of faulted requests

Behaviour:
- Single clock, clk. Reset is synchronous, active-low on rst_n, sampled at posedge clk.
- Reset values: state=IDLE; req_ready=1; resp_valid=0; resp_data=0; resp_fault=0; mem_addr=0; mem_write_data=0; mem_enable_write=0; fault_count=0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at an edge: latch write, addr and wdata into mem_addr and mem_write_data.
  - Compute in_range = addr within either window, both bounds inclusive. Addresses in the gap between windows, below STATIC_BASE, or above the dynamic top are out of range.
  - in_range -> ACCESS.
  - Not in range -> RESP with resp_fault=1, resp_data=0, and fault_count+1 (saturating at 255). Memory is never touched.
- ACCESS (exactly 1 cycle):
  - req_ready=0.
  - Store: mem_enable_write=1 for this cycle only.
  - Load: mem_enable_write=0, and mem_read_out is registered into resp_data at the closing edge.
  - Next state is RESP with resp_fault=0; resp_data=0 for stores.
- RESP:
  - resp_valid=1; resp_data and resp_fault are held stable until resp_ready is sampled high.
  - Then go to IDLE and clear resp_valid.
  - req_ready=0 throughout; there is no overlap of response and new request.
- Latency, with the request accepted at edge N:
  - In-range: resp_valid rises after edge N+1, with the response visible during cycle N+2.
  - Fault: resp_valid visible during cycle N+1.
  - Throughput: at most 1 request per 3 cycles.
- mem_enable_write = (state==ACCESS) && write && rst_n, gated combinationally. A reset asserted during ACCESS therefore suppresses the write.
- mem_addr and mem_write_data hold their last latched values outside ACCESS. mem_enable_write=0 guarantees no side effect.
- Reset mid-operation: the pending request and response are dropped, all outputs take reset values, and no response is issued.
- req_* is ignored outside IDLE.
- resp_ready high while resp_valid=0 has no effect.

Test Plan:
- Store 32'hDEADBEEF to 16'h0010, then load 16'h0010 -> exactly one mem_enable_write pulse during the store's ACCESS cycle; load response resp_data=32'hDEADBEEF, resp_fault=0, resp_valid two cycles after the load is accepted.
- Store 32'h12345678 to 16'h8FFF (dynamic top, inclusive), then load it back -> resp_data=32'h12345678, no fault.
- Load 16'h1000 (gap) and store to 16'h9000 (above dynamic top) -> both give resp_fault=1, resp_data=0, mem_enable_write never asserted, fault_count=2, response one cycle after accept.
- Hold resp_ready=0 for 5 cycles after a load of 16'h0010 -> resp_valid, resp_data and resp_fault stay stable, req_ready stays 0, and a req_valid pulse in that time is ignored; resp_ready=1 -> IDLE next cycle.
- Issue 260 out-of-range requests -> fault_count saturates at 8'd255.
- Assert rst_n=0 during the ACCESS cycle of a store of 32'hAAAA5555 to 16'h0020 -> mem_enable_write=0 that cycle, no response issued, and a later load of 16'h0020 returns the previous value.
